// File: rtl/apb_master.sv
// apb_master - bridges single CPU requests onto a four-slave APB bus.
//
// State table:
//   state  | meaning
//   IDLE   | bus quiet; samples transfer/write/addr/wdata
//   SETUP  | PSEL[slot] high, PENABLE low, timeout counter cleared
//   ACCESS | PSEL[slot] and PENABLE high; waits for PREADY[slot] or timeout
//   DONE   | one-cycle ready pulse to the CPU, err qualifies it
//
// Ports:
//   clk, reset (async active-low)
//   CPU side : transfer, write, addr[31:0], wdata[31:0] in; rdata[31:0], ready, err out
//   APB side : PADDR[31:0], PWDATA[31:0], PWRITE, PENABLE, PSEL[3:0] out;
//              PRDATA0..3[31:0], PREADY0..3 in
// Address map (addr[31:12]): 0x10000 RAM, 0x10001 GPO, 0x10002 GPI, 0x10003 GPIO.
module apb_master #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PENABLE,
  output logic [3:0]  PSEL,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic        penable_q, penable_d;
  logic [3:0]  psel_q, psel_d;
  logic [1:0]  slot_q, slot_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic        mapped;
  logic [1:0]  slot_in;
  logic        pready_sel;
  logic [31:0] prdata_sel;

  always_comb begin
    mapped  = 1'b1;
    slot_in = 2'd0;
    case (addr[31:12])
      20'h10000: slot_in = 2'd0;
      20'h10001: slot_in = 2'd1;
      20'h10002: slot_in = 2'd2;
      20'h10003: slot_in = 2'd3;
      default:   mapped  = 1'b0;
    endcase
  end

  // Only the latched slot's handshake is observed.
  always_comb begin
    case (slot_q)
      2'd0:    begin pready_sel = PREADY0; prdata_sel = PRDATA0; end
      2'd1:    begin pready_sel = PREADY1; prdata_sel = PRDATA1; end
      2'd2:    begin pready_sel = PREADY2; prdata_sel = PRDATA2; end
      default: begin pready_sel = PREADY3; prdata_sel = PRDATA3; end
    endcase
  end

  // Outputs are computed for the next state so every bus/CPU output is a flop.
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    psel_d    = 4'b0000;
    penable_d = 1'b0;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          if (mapped) begin
            paddr_d  = addr;
            pwdata_d = wdata;
            pwrite_d = write;
            slot_d   = slot_in;
            psel_d   = 4'b0001 << slot_in;
            state_d  = SETUP;
          end else begin
            rdata_d = 32'h0;
            ready_d = 1'b1;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      SETUP: begin
        cnt_d     = 8'h0;
        psel_d    = psel_q;
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready_sel) begin
          if (!pwrite_q) rdata_d = prdata_sel;
          ready_d = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'h0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d     = cnt_q + 8'h1;
          psel_d    = psel_q;
          penable_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      paddr_q   <= 32'h0;
      pwdata_q  <= 32'h0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      psel_q    <= 4'b0000;
      slot_q    <= 2'd0;
      cnt_q     <= 8'h0;
      rdata_q   <= 32'h0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      psel_q    <= psel_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign PENABLE = penable_q;
  assign PSEL    = psel_q;
  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;

endmodule
